// File: rtl/vid_timing_pkg.sv
// Shared constants for the parametrised video timing generator: default counter
// width, sync polarities, shadow-config states and standard CEA/VESA modes.
package vid_timing_pkg;

  localparam int unsigned CwDefault = 12;

  localparam bit PolPos = 1'b1;
  localparam bit PolNeg = 1'b0;

  localparam logic [1:0] StLoad = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  typedef struct packed {
    int unsigned h_total;
    int unsigned h_sync;
    int unsigned h_bporch;
    int unsigned h_res;
    int unsigned v_total;
    int unsigned v_sync;
    int unsigned v_bporch;
    int unsigned v_res;
  } vid_mode_t;

  // 1280x720 @ 74.25 MHz
  localparam vid_mode_t Mode720p = '{h_total: 1650, h_sync: 40, h_bporch: 220, h_res: 1280,
                                     v_total: 750, v_sync: 5, v_bporch: 20, v_res: 720};
  // 800x600 @ 40 MHz
  localparam vid_mode_t Mode800x600 = '{h_total: 1056, h_sync: 128, h_bporch: 88, h_res: 800,
                                        v_total: 628, v_sync: 4, v_bporch: 23, v_res: 600};
  // 1024x768 @ 65 MHz
  localparam vid_mode_t Mode1024x768 = '{h_total: 1344, h_sync: 136, h_bporch: 160,
                                         h_res: 1024, v_total: 806, v_sync: 6, v_bporch: 29,
                                         v_res: 768};

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to align sync/enable levels with the FIFO read latency;
// every stage resets to RstVal so a reset flushes the line to inactive levels.
module sync_delay_line #(
  parameter int unsigned  W      = 1,
  parameter int unsigned  DLY    = 1,
  parameter logic [W-1:0] RstVal = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DLY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DLY; i++) stage_q[i] <= RstVal;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DLY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DLY-1];

endmodule

// File: rtl/vid_timing_gen.sv
// Parametrised video timing generator: HS/VS/DE for the TMDS path plus a FIFO read window
// that leads DE by DLY cycles. Timing is shadowed and only changes at frame boundaries.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned CW     = CwDefault,
  parameter int unsigned DLY    = 5,
  parameter bit          HS_POL = PolPos,
  parameter bit          VS_POL = PolPos
) (
  input  logic          I_pxl_clk,
  input  logic          I_rst_n,
  input  logic [CW-1:0] I_h_total,
  input  logic [CW-1:0] I_h_sync,
  input  logic [CW-1:0] I_h_bporch,
  input  logic [CW-1:0] I_h_res,
  input  logic [CW-1:0] I_v_total,
  input  logic [CW-1:0] I_v_sync,
  input  logic [CW-1:0] I_v_bporch,
  input  logic [CW-1:0] I_v_res,
  input  logic [CW-1:0] I_rd_hres,
  input  logic [CW-1:0] I_rd_vres,
  input  logic          I_center,
  output logic          O_rden,
  output logic          O_de,
  output logic          O_hs,
  output logic          O_vs,
  output logic [CW-1:0] O_x,
  output logic [CW-1:0] O_y,
  output logic          O_sof,
  output logic          O_cfg_err
);

  localparam int unsigned EW = CW + 2;

  // Input-side derivation, evaluated on the capture cycle.
  logic [EW-1:0] in_ha_w, in_va_w, in_hae, in_vae;
  logic [CW-1:0] in_ha, in_va, in_rw, in_rh, in_ox, in_oy;
  logic [CW-1:0] in_wx0, in_wx1, in_wy0, in_wy1;
  logic          in_bad, in_clamp;

  always_comb begin
    in_ha_w  = EW'(I_h_sync) + EW'(I_h_bporch);
    in_va_w  = EW'(I_v_sync) + EW'(I_v_bporch);
    in_hae   = in_ha_w + EW'(I_h_res);
    in_vae   = in_va_w + EW'(I_v_res);
    in_ha    = CW'(in_ha_w);
    in_va    = CW'(in_va_w);
    in_rw    = (I_rd_hres < I_h_res) ? I_rd_hres : I_h_res;
    in_rh    = (I_rd_vres < I_v_res) ? I_rd_vres : I_v_res;
    in_clamp = (I_rd_hres > I_h_res) || (I_rd_vres > I_v_res);
    in_ox    = I_center ? ((I_h_res - in_rw) >> 1) : '0;
    in_oy    = I_center ? ((I_v_res - in_rh) >> 1) : '0;
    in_wx0   = in_ha + in_ox;
    in_wx1   = in_wx0 + in_rw;
    in_wy0   = in_va + in_oy;
    in_wy1   = in_wy0 + in_rh;
    in_bad   = (I_h_total == '0) || (I_v_total == '0) ||
               (in_hae > EW'(I_h_total)) || (in_vae > EW'(I_v_total));
  end

  logic [1:0]    st_q, st_d;
  logic [CW-1:0] h_total_q, v_total_q, h_sync_q, v_sync_q;
  logic [CW-1:0] ha_q, hae_q, va_q, vae_q, wx0_q, wx1_q, wy0_q, wy1_q;
  logic          err_q;
  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          run, h_last, v_last, frame_end, capture;

  assign run       = (st_q == StRun);
  assign h_last    = (h_cnt_q == h_total_q - CW'(1));
  assign v_last    = (v_cnt_q == v_total_q - CW'(1));
  assign frame_end = run && h_last && v_last;
  // Waiting-for-load and held-invalid states both behave as a permanent frame end.
  assign capture   = !run || frame_end;

  always_comb begin
    st_d = st_q;
    if (capture) st_d = in_bad ? StHold : StRun;
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      st_q      <= StLoad;
      h_total_q <= '0;
      v_total_q <= '0;
      h_sync_q  <= '0;
      v_sync_q  <= '0;
      ha_q      <= '0;
      hae_q     <= '0;
      va_q      <= '0;
      vae_q     <= '0;
      wx0_q     <= '0;
      wx1_q     <= '0;
      wy0_q     <= '0;
      wy1_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      st_q <= st_d;
      if (capture) begin
        h_total_q <= I_h_total;
        v_total_q <= I_v_total;
        h_sync_q  <= I_h_sync;
        v_sync_q  <= I_v_sync;
        ha_q      <= in_ha;
        hae_q     <= CW'(in_hae);
        va_q      <= in_va;
        vae_q     <= CW'(in_vae);
        wx0_q     <= in_wx0;
        wx1_q     <= in_wx1;
        wy0_q     <= in_wy0;
        wy1_q     <= in_wy1;
        err_q     <= in_bad || in_clamp;
      end
    end
  end

  always_comb begin
    h_cnt_d = h_cnt_q + CW'(1);
    v_cnt_d = v_cnt_q;
    if (!run) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
    end
  end

  logic          hs_raw, vs_raw, de_raw, rden_raw, sof_raw;
  logic [CW-1:0] x_raw, y_raw;

  always_comb begin
    hs_raw   = run && (h_cnt_q < h_sync_q);
    vs_raw   = run && (v_cnt_q < v_sync_q);
    de_raw   = run && (h_cnt_q >= ha_q) && (h_cnt_q < hae_q) &&
               (v_cnt_q >= va_q) && (v_cnt_q < vae_q);
    rden_raw = run && (h_cnt_q >= wx0_q) && (h_cnt_q < wx1_q) &&
               (v_cnt_q >= wy0_q) && (v_cnt_q < wy1_q);
    sof_raw  = rden_raw && (h_cnt_q == wx0_q) && (v_cnt_q == wy0_q);
    x_raw    = rden_raw ? (h_cnt_q - wx0_q) : '0;
    y_raw    = rden_raw ? (v_cnt_q - wy0_q) : '0;
  end

  logic          rden_q, sof_q, hs_q, vs_q, de_q;
  logic [CW-1:0] x_q, y_q;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      rden_q  <= 1'b0;
      sof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rden_q  <= rden_raw;
      sof_q   <= sof_raw;
      x_q     <= x_raw;
      y_q     <= y_raw;
      hs_q    <= hs_raw ? HS_POL : ~HS_POL;
      vs_q    <= vs_raw ? VS_POL : ~VS_POL;
      de_q    <= de_raw;
    end
  end

  // Lines are held at physical (polarity-applied) levels so reset flushes them inactive.
  logic [2:0] dly_q;

  sync_delay_line #(
    .W      (3),
    .DLY    (DLY),
    .RstVal ({~HS_POL, ~VS_POL, 1'b0})
  ) u_sync_delay_line (
    .clk_i  (I_pxl_clk),
    .rst_ni (I_rst_n),
    .d_i    ({hs_q, vs_q, de_q}),
    .q_o    (dly_q)
  );

  assign O_hs      = dly_q[2];
  assign O_vs      = dly_q[1];
  assign O_de      = dly_q[0];
  assign O_rden    = rden_q;
  assign O_sof     = sof_q;
  assign O_x       = x_q;
  assign O_y       = y_q;
  assign O_cfg_err = err_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen using small scaled modes so whole frames fit the run,
// plus a short 720p line-timing check. HS is active-low here, VS active-high.
module tb_vid_timing_gen;
  import vid_timing_pkg::*;

  localparam int unsigned CW  = 12;
  localparam int          DLY = 5;

  // Mode A: ha=10 va=5, 40x20 frame; mode B: ha=7 va=3, 30x14 frame.
  localparam vid_mode_t ModeA = '{h_total: 40, h_sync: 4, h_bporch: 6, h_res: 24,
                                  v_total: 20, v_sync: 2, v_bporch: 3, v_res: 12};
  localparam vid_mode_t ModeB = '{h_total: 30, h_sync: 3, h_bporch: 4, h_res: 16,
                                  v_total: 14, v_sync: 1, v_bporch: 2, v_res: 8};

  logic          pxl_clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
  logic [CW-1:0] rd_hres, rd_vres;
  logic          center;
  logic          rden, de, hs, vs, sof, cfg_err;
  logic [CW-1:0] x, y;

  int checks = 0;
  int errors = 0;
  vid_mode_t m;

  always #5 pxl_clk = ~pxl_clk;

  vid_timing_gen #(
    .CW     (CW),
    .DLY    (DLY),
    .HS_POL (1'b0),
    .VS_POL (1'b1)
  ) dut (
    .I_pxl_clk  (pxl_clk),
    .I_rst_n    (rst_n),
    .I_h_total  (h_total),
    .I_h_sync   (h_sync),
    .I_h_bporch (h_bporch),
    .I_h_res    (h_res),
    .I_v_total  (v_total),
    .I_v_sync   (v_sync),
    .I_v_bporch (v_bporch),
    .I_v_res    (v_res),
    .I_rd_hres  (rd_hres),
    .I_rd_vres  (rd_vres),
    .I_center   (center),
    .O_rden     (rden),
    .O_de       (de),
    .O_hs       (hs),
    .O_vs       (vs),
    .O_x        (x),
    .O_y        (y),
    .O_sof      (sof),
    .O_cfg_err  (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input vid_mode_t md);
    m        = md;
    h_total  = CW'(md.h_total);
    h_sync   = CW'(md.h_sync);
    h_bporch = CW'(md.h_bporch);
    h_res    = CW'(md.h_res);
    v_total  = CW'(md.v_total);
    v_sync   = CW'(md.v_sync);
    v_bporch = CW'(md.v_bporch);
    v_res    = CW'(md.v_res);
  endtask

  task automatic set_rd(input int w, input int h, input logic c);
    rd_hres = CW'(w);
    rd_vres = CW'(h);
    center  = c;
  endtask

  // Negedges until O_sof is seen; -1 if the budget runs out.
  task automatic wait_sof(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge pxl_clk);
      if (sof === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // Starting on an O_sof sample, checks one full frame against the timing formulas.
  task automatic scan(input string tag, input int wx0, input int wy0, input int rw, input int rh);
    int f, s, idx, h, v, idd, hd, vd, ha, va;
    int e_rden, e_xy, e_sof, e_de, e_hs, e_vs;
    bit exp_rden, exp_de;
    f  = int'(m.h_total * m.v_total);
    s  = wy0 * int'(m.h_total) + wx0;
    ha = int'(m.h_sync + m.h_bporch);
    va = int'(m.v_sync + m.v_bporch);
    e_rden = 0; e_xy = 0; e_sof = 0; e_de = 0; e_hs = 0; e_vs = 0;
    for (int j = 0; j < f; j++) begin
      idx = (s + j) % f;
      h   = idx % int'(m.h_total);
      v   = idx / int'(m.h_total);
      idd = (s + j - DLY + f) % f;
      hd  = idd % int'(m.h_total);
      vd  = idd / int'(m.h_total);
      exp_rden = (h >= wx0) && (h < wx0 + rw) && (v >= wy0) && (v < wy0 + rh);
      exp_de   = (hd >= ha) && (hd < ha + int'(m.h_res)) &&
                 (vd >= va) && (vd < va + int'(m.v_res));
      if (rden !== exp_rden) e_rden++;
      if (exp_rden && ((x !== CW'(h - wx0)) || (y !== CW'(v - wy0)))) e_xy++;
      if (sof !== (j == 0)) e_sof++;
      if (de !== exp_de) e_de++;
      if (hs !== !(hd < int'(m.h_sync))) e_hs++;
      if (vs !== (vd < int'(m.v_sync))) e_vs++;
      @(negedge pxl_clk);
    end
    chk({tag, "_rden"}, e_rden, 0);
    chk({tag, "_xy"}, e_xy, 0);
    chk({tag, "_sof"}, e_sof, 0);
    chk({tag, "_de"}, e_de, 0);
    chk({tag, "_hs"}, e_hs, 0);
    chk({tag, "_vs"}, e_vs, 0);
  endtask

  initial begin
    int n, w, p, c_rden, c_de, c_hs, c_vs;

    rst_n = 1'b0;
    set_mode(ModeA);
    set_rd(12, 6, 1'b1);
    repeat (3) @(negedge pxl_clk);
    chk("rst_rden", rden, 0);
    chk("rst_de", de, 0);
    chk("rst_sof", sof, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Centred 12x6 window in mode A: window at h 16..27, lines 8..13, sof index 336.
    rst_n = 1'b1;
    wait_sof(2000, n);
    chk("first_sof_latency", n, 338);
    chk("center_cfg_err", cfg_err, 0);
    scan("center", 16, 8, 12, 6);

    // Top-left switch mid-frame: takes effect next frame, sof at index 210.
    center = 1'b0;
    wait_sof(2000, n);
    chk("tl_sof_interval", n, 674);
    scan("tl", 10, 5, 12, 6);

    // Mode change mid-frame: current frame keeps 800-cycle length, B sof at 161.
    repeat (100) @(negedge pxl_clk);
    set_mode(ModeB);
    set_rd(8, 4, 1'b1);
    wait_sof(2000, n);
    chk("modeb_sof_interval", n, 651);
    chk("modeb_cfg_err", cfg_err, 0);
    scan("modeb", 11, 5, 8, 4);

    // Oversized read width clamps to the full active line.
    set_mode(ModeA);
    set_rd(100, 12, 1'b1);
    wait_sof(2000, n);
    chk("clamp_sof_interval", n, 469);
    chk("clamp_cfg_err", cfg_err, 1);
    scan("clamp", 10, 5, 24, 12);
    chk("clamp_rden_at_sof", rden, 1);
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge pxl_clk);
      if (de === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("de_after_rden", n, DLY);

    // Invalid back porch: outputs held inactive once the frame ends.
    h_bporch = CW'(2000);
    set_rd(12, 6, 1'b1);
    repeat (800) @(negedge pxl_clk);
    c_rden = 0; c_de = 0; c_hs = 0; c_vs = 0;
    for (int k = 0; k < 40; k++) begin
      if (rden !== 1'b0) c_rden++;
      if (de !== 1'b0) c_de++;
      if (hs !== 1'b1) c_hs++;
      if (vs !== 1'b0) c_vs++;
      @(negedge pxl_clk);
    end
    chk("bad_cfg_err", cfg_err, 1);
    chk("bad_rden_held", c_rden, 0);
    chk("bad_de_held", c_de, 0);
    chk("bad_hs_inactive", c_hs, 0);
    chk("bad_vs_inactive", c_vs, 0);

    h_bporch = CW'(6);
    wait_sof(2000, n);
    chk("restore_sof_latency", n, 338);
    chk("restore_cfg_err", cfg_err, 0);

    // Reset while HS is active must force it inactive at once.
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge pxl_clk);
      if (hs === 1'b0) begin
        n = k;
        break;
      end
    end
    chk("hs_active_before_rst", n, 29);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_hs", hs, 1);
    chk("midrst_de", de, 0);
    chk("midrst_rden", rden, 0);
    chk("midrst_vs", vs, 0);
    @(negedge pxl_clk);
    rst_n = 1'b1;
    wait_sof(2000, n);
    chk("midrst_restart_sof", n, 338);

    // 720p line timing: HS first active DLY+2 samples after release, 40 wide, 1650 period.
    @(negedge pxl_clk);
    rst_n = 1'b0;
    set_mode(Mode720p);
    set_rd(1280, 720, 1'b1);
    @(negedge pxl_clk);
    rst_n = 1'b1;
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge pxl_clk);
      if (hs === 1'b0) begin
        n = k;
        break;
      end
    end
    chk("p720_hs_first", n, DLY + 2);
    w = 1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge pxl_clk);
      if (hs !== 1'b0) break;
      w++;
    end
    chk("p720_hs_width", w, 40);
    p = w;
    for (int k = 0; k < 4000; k++) begin
      @(negedge pxl_clk);
      p++;
      if (hs === 1'b0) break;
    end
    chk("p720_hs_period", p, 1650);
    chk("p720_cfg_err", cfg_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
